// File: rtl/crank_trigger_gen_pkg.sv
// crank_trigger_gen_pkg: shared types, defaults and helpers for the crank
// trigger-wheel generator.
package crank_trigger_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int TOOTH_NUM_DEF = 60;
    localparam int GAP_NUM_DEF   = 2;
    localparam int PERIOD_MIN    = 2;

    // Missing teeth sit at the top of the wheel: TOOTH_NUM-GAP_NUM..TOOTH_NUM-1.
    function automatic logic gap_tooth(input logic [5:0] tooth,
                                       input int         tooth_num,
                                       input int         gap_num);
        return (int'(tooth) >= (tooth_num - gap_num));
    endfunction

endpackage

// File: rtl/crank_trigger_gen_timer.sv
// crank_tooth_timer: per-tooth phase counter with a period latch that only
// reloads at tooth boundaries, clamping short periods to PERIOD_MIN.
module crank_tooth_timer
    import crank_trigger_gen_pkg::*;
#(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                run,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period,
    output logic [PERIOD_W-1:0] phase,
    output logic [PERIOD_W-1:0] period_lat,
    output logic                tooth_end,
    output logic                tick
);

    logic [PERIOD_W-1:0] phase_q, phase_d;
    logic [PERIOD_W-1:0] period_lat_q, period_lat_d;
    logic                tick_q, tick_d;
    logic [PERIOD_W-1:0] period_cl;

    assign period_cl = (period < PERIOD_W'(PERIOD_MIN)) ? PERIOD_W'(PERIOD_MIN) : period;
    assign tooth_end = run && (phase_q == (period_lat_q - PERIOD_W'(1)));

    // Advance phase; latch a fresh period on start and at every tooth end.
    always_comb begin
        phase_d      = phase_q;
        period_lat_d = period_lat_q;
        tick_d       = 1'b0;
        if (start) begin
            phase_d      = '0;
            period_lat_d = period_cl;
        end else if (tooth_end) begin
            phase_d      = '0;
            period_lat_d = period_cl;
            tick_d       = !stop;
        end else if (run) begin
            phase_d = phase_q + PERIOD_W'(1);
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= '0;
            period_lat_q <= '0;
            tick_q       <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            period_lat_q <= period_lat_d;
            tick_q       <= tick_d;
        end
    end

    assign phase      = phase_q;
    assign period_lat = period_lat_q;
    assign tick       = tick_q;

endmodule

// File: rtl/crank_trigger_gen.sv
// crank_trigger_gen: synthetic crank (cap) / cam trigger-wheel generator for a
// TOOTH_NUM-minus-GAP_NUM wheel. Cam output and revolution parity exist only
// when CRANK_TRIGGER_GEN_CAM_EN is defined; otherwise both are tied to 0.
module crank_trigger_gen
    import crank_trigger_gen_pkg::*;
#(
    parameter int TOOTH_NUM = TOOTH_NUM_DEF,
    parameter int GAP_NUM   = GAP_NUM_DEF,
    parameter int PERIOD_W  = 24,
    parameter int CAM_START = 10,
    parameter int CAM_LEN   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [PERIOD_W-1:0] period,
    output logic                cap,
    output logic                cam,
    output logic [5:0]          tooth_num,
    output logic                rev,
    output logic                tooth_stb,
    output logic                busy
);

    if (TOOTH_NUM < 8 || TOOTH_NUM > 63) begin : g_bad_tooth_num
        $error("crank_trigger_gen: TOOTH_NUM must be 8..63");
    end
    if (GAP_NUM < 1 || GAP_NUM > 3) begin : g_bad_gap_num
        $error("crank_trigger_gen: GAP_NUM must be 1..3");
    end
    if (CAM_LEN < 1 || CAM_START + CAM_LEN > TOOTH_NUM) begin : g_bad_cam
        $error("crank_trigger_gen: cam window must lie inside the wheel");
    end

    state_e              state_q, state_d;
    logic                start, run, stop;
    logic                tooth_end, tick, wrap, clear;
    logic [PERIOD_W-1:0] phase, period_lat;
    logic [5:0]          tooth_q, tooth_d;
    logic                cap_q, cap_d;
    logic                busy_q, busy_d;
    logic                tooth_stb_q, tooth_stb_d;
    logic [5:0]          tooth_num_q, tooth_num_d;

    crank_tooth_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst),
        .start      (start),
        .run        (run),
        .stop       (stop),
        .period     (period),
        .phase      (phase),
        .period_lat (period_lat),
        .tooth_end  (tooth_end),
        .tick       (tick)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next state: draining finishes the current tooth unless re-enabled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ena) state_d = RUN;
            RUN:     if (!ena) state_d = DRAIN;
            DRAIN:   if (ena) state_d = RUN;
                     else if (tooth_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: control strobes for the timer and counters.
    always_comb begin
        start = (state_q == IDLE) && ena;
        run   = (state_q != IDLE);
        stop  = (state_q == DRAIN) && !ena;
    end

    assign wrap  = (tooth_q == 6'(TOOTH_NUM - 1));
    assign clear = start || (tooth_end && stop);

    // Tooth position: restart at 0, step at each tooth end, wrap at wheel end.
    always_comb begin
        tooth_d = tooth_q;
        if (clear)          tooth_d = '0;
        else if (tooth_end) tooth_d = wrap ? 6'd0 : tooth_q + 6'd1;
    end

    // Next values of the registered outputs.
    always_comb begin
        busy_d      = run;
        cap_d       = run && !gap_tooth(tooth_q, TOOTH_NUM, GAP_NUM)
                      && (phase < (period_lat >> 1));
        tooth_num_d = tooth_q;
        tooth_stb_d = tick;
    end

    // Tooth counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tooth_q     <= '0;
            cap_q       <= 1'b0;
            busy_q      <= 1'b0;
            tooth_stb_q <= 1'b0;
            tooth_num_q <= '0;
        end else begin
            tooth_q     <= tooth_d;
            cap_q       <= cap_d;
            busy_q      <= busy_d;
            tooth_stb_q <= tooth_stb_d;
            tooth_num_q <= tooth_num_d;
        end
    end

    assign cap       = cap_q;
    assign busy      = busy_q;
    assign tooth_stb = tooth_stb_q;
    assign tooth_num = tooth_num_q;

`ifdef CRANK_TRIGGER_GEN_CAM_EN
    logic rev_q, rev_d;
    logic cam_q, cam_d;
    logic rev_out_q, rev_out_d;

    // Revolution parity flips on each wheel wrap; cam fires in revolution 0 only.
    always_comb begin
        rev_d = rev_q;
        if (clear)                  rev_d = 1'b0;
        else if (tooth_end && wrap) rev_d = ~rev_q;
        cam_d     = run && !rev_q && (int'(tooth_q) >= CAM_START)
                    && (int'(tooth_q) < CAM_START + CAM_LEN);
        rev_out_d = rev_q;
    end

    // Revolution counter and cam/rev output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rev_q     <= 1'b0;
            cam_q     <= 1'b0;
            rev_out_q <= 1'b0;
        end else begin
            rev_q     <= rev_d;
            cam_q     <= cam_d;
            rev_out_q <= rev_out_d;
        end
    end

    assign cam = cam_q;
    assign rev = rev_out_q;
`else
    assign cam = 1'b0;
    assign rev = 1'b0;
`endif

endmodule

// File: tb/tb_crank_trigger_gen.sv
// tb_crank_trigger_gen: scoreboard bench for crank_trigger_gen. Expected cap
// high times and fall-to-fall intervals are queued before each run and popped
// as the monitor sees cap edges.
`timescale 1ns/1ps
module tb_crank_trigger_gen;

    localparam int TN = 60;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [23:0] period;
    logic        cap, cam, rev, tooth_stb, busy;
    logic [5:0]  tooth_num;

    crank_trigger_gen dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .period    (period),
        .cap       (cap),
        .cam       (cam),
        .tooth_num (tooth_num),
        .rev       (rev),
        .tooth_stb (tooth_stb),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // scoreboard queues
    int exp_int[$];
    int exp_high[$];

    // monitor state (owned by the monitor process)
    bit mon_en = 1'b0;
    bit prev_cap, prev_cam, have_rise, have_fall;
    int rise_t, fall_t, stb_cnt, cam_cyc, cam_starts, rev_cyc, exp_tooth;

    always @(negedge clk) begin
        if (!mon_en) begin
            have_rise  = 1'b0;
            have_fall  = 1'b0;
            prev_cap   = cap;
            prev_cam   = cam;
            stb_cnt    = 0;
            cam_cyc    = 0;
            cam_starts = 0;
            rev_cyc    = 0;
            exp_tooth  = 0;
        end else begin
            if (cap && !prev_cap) begin
                rise_t    = cyc;
                have_rise = 1'b1;
            end
            if (!cap && prev_cap) begin
                if (have_rise) begin
                    if (exp_high.size() > 0) check("cap_high", cyc - rise_t, exp_high.pop_front());
                    else                     check("cap_high_extra", cyc - rise_t, 0);
                end
                if (have_fall) begin
                    if (exp_int.size() > 0) check("fall_interval", cyc - fall_t, exp_int.pop_front());
                    else                    check("fall_interval_extra", cyc - fall_t, 0);
                end
                fall_t    = cyc;
                have_fall = 1'b1;
            end
            if (tooth_stb) begin
                stb_cnt++;
                exp_tooth = (exp_tooth + 1) % TN;
                check("tooth_at_stb", tooth_num, exp_tooth);
            end
            if (cam) cam_cyc++;
            if (cam && !prev_cam) begin
                cam_starts++;
                check("cam_start_tooth", tooth_num, 10);
            end
            if (rev) rev_cyc++;
            prev_cap = cap;
            prev_cam = cam;
        end
    end

    task automatic push_run(input int n, input int val, input bit is_int);
        for (int i = 0; i < n; i++) begin
            if (is_int) exp_int.push_back(val);
            else        exp_high.push_back(val);
        end
    endtask

    task automatic start_run(input logic [23:0] p);
        @(negedge clk);
        period = p;
        ena    = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_int_left"},  exp_int.size(),  0);
        check({tag, "_high_left"}, exp_high.size(), 0);
    endtask

    task automatic rst_mid();
        @(posedge clk);
        #3;
        rst = 1'b0;
        ena = 1'b0;
        #1;
        check("rst_cap",   cap,       0);
        check("rst_cam",   cam,       0);
        check("rst_busy",  busy,      0);
        check("rst_stb",   tooth_stb, 0);
        check("rst_tooth", tooth_num, 0);
        check("rst_rev",   rev,       0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst    = 1'b0;
        ena    = 1'b0;
        period = 24'd100;
        #12;
        check("init_busy",  busy,      0);
        check("init_cap",   cap,       0);
        check("init_tooth", tooth_num, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_cap",  cap,  0);

        // Two revolutions at period 100.
        for (int r = 0; r < 2; r++) begin
            push_run(57, 100, 1'b1);
            push_run(1, 300, 1'b1);
        end
        push_run(117, 50, 1'b0);
        start_run(24'd100);
        repeat (12060) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check_drained("s1");
        check("s1_stb_count", stb_cnt, 120);
`ifdef CRANK_TRIGGER_GEN_CAM_EN
        check("s1_cam_cycles", cam_cyc,    200);
        check("s1_cam_starts", cam_starts, 1);
        check("s1_rev_cycles", rev_cyc,    6000);
`else
        check("s1_cam_cycles", cam_cyc, 0);
        check("s1_rev_cycles", rev_cyc, 0);
`endif
        check("s1_busy", busy, 1);
        rst_mid();

        // Period 101, rewritten to 60 in the middle of tooth 5.
        push_run(6, 50, 1'b0);
        push_run(5, 30, 1'b0);
        push_run(5, 101, 1'b1);
        push_run(1, 81, 1'b1);
        push_run(4, 60, 1'b1);
        start_run(24'd101);
        repeat (547) @(posedge clk);
        #2;
        period = 24'd60;
        repeat (360) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check_drained("s2");
        check("s2_stb_count", stb_cnt, 10);
        check("s2_busy", busy, 1);
        check("s2_tooth", tooth_num, 10);
        rst_mid();

        // Period 0 clamps to 2.
        push_run(57, 2, 1'b1);
        push_run(1, 6, 1'b1);
        push_run(3, 2, 1'b1);
        push_run(62, 1, 1'b0);
        start_run(24'd0);
        repeat (130) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check_drained("s3");
        check("s3_stb_count", stb_cnt, 63);
        rst_mid();

        // ena dropped at phase ~20 of tooth 7, then restart.
        push_run(8, 50, 1'b0);
        push_run(7, 100, 1'b1);
        start_run(24'd100);
        repeat (721) @(posedge clk);
        #2;
        ena = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        check("drain_busy",  busy,      1);
        check("drain_tooth", tooth_num, 7);
        @(posedge clk);
        #1;
        check("drained_busy",  busy,      0);
        check("drained_cap",   cap,       0);
        check("drained_tooth", tooth_num, 0);
        check("drained_stb",   tooth_stb, 0);
        mon_en = 1'b0;
        check_drained("s4");
        check("s4_stb_count", stb_cnt, 7);
        repeat (5) @(posedge clk);
        #1;
        check("idle_after_drain", busy, 0);
        @(negedge clk);
        ena = 1'b1;
        @(posedge clk);
        #1;
        check("restart_busy_n1", busy, 0);
        @(posedge clk);
        #1;
        check("restart_busy",  busy,      1);
        check("restart_cap",   cap,       1);
        check("restart_tooth", tooth_num, 0);
        repeat (100) @(posedge clk);
        #1;
        check("restart_tooth1", tooth_num, 1);
        check("restart_rev",    rev,       0);
        rst_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
